// File: rtl/pin_bank.sv
// pin_bank: bank of NCHAN pin channels (off/const/square/pwm/input) on the EBI register bus.
// Define PIN_BANK_CAPTURE_EN to build the timestamped edge-capture FIFO, capture mask and irq.
module pin_bank #(
   parameter int unsigned NCHAN      = 16,
   parameter int unsigned BASE       = 0,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic              data_wr,
   input  logic              data_rd,
   input  logic [15:0]       data_in,
   output logic [15:0]       data_out,
   input  logic [NCHAN-1:0]  pin_in,
   output logic [NCHAN-1:0]  pin_out,
   output logic [NCHAN-1:0]  pin_oe,
   output logic              irq
);

   localparam int unsigned CH_WORDS  = 4 * NCHAN;
   localparam int unsigned WIN_WORDS = CH_WORDS + 3;
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] G_OFF  = ADDR_W'(CH_WORDS);
   localparam logic [ADDR_W-1:0] WIN_SZ = ADDR_W'(WIN_WORDS);

   localparam logic [2:0] MODE_OFF   = 3'd0;
   localparam logic [2:0] MODE_CONST = 3'd1;
   localparam logic [2:0] MODE_SQ    = 3'd2;
   localparam logic [2:0] MODE_PWM   = 3'd3;
   localparam logic [2:0] MODE_IN    = 3'd4;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_DUTY   = 2'd2;

   // EBI strobe synchronisers and edge detection
   logic [1:0] r_en_sync, r_wr_sync, r_rd_sync;
   logic       r_wr_q;
   logic       w_wr_s, w_rd_s, w_wr_commit;

   assign w_wr_s      = r_en_sync[1] & r_wr_sync[1];
   assign w_rd_s      = r_en_sync[1] & r_rd_sync[1];
   assign w_wr_commit = w_wr_s & ~r_wr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en_sync <= '0;
         r_wr_sync <= '0;
         r_rd_sync <= '0;
         r_wr_q    <= 1'b0;
      end else begin
         r_en_sync <= {r_en_sync[0], enable};
         r_wr_sync <= {r_wr_sync[0], data_wr};
         r_rd_sync <= {r_rd_sync[0], data_rd};
         r_wr_q    <= w_wr_s;
      end
   end

   // Window decode; an address below BASE wraps to a large offset and misses the window
   logic [ADDR_W-1:0] w_off;
   logic              w_in_win, w_is_ch;
   logic [3:0]        w_ch_idx;
   logic [1:0]        w_reg;

   assign w_off    = addr - BASE_A;
   assign w_in_win = (w_off < WIN_SZ);
   assign w_is_ch  = w_in_win && (w_off < G_OFF);
   assign w_ch_idx = w_off[5:2];
   assign w_reg    = w_off[1:0];

   logic [NCHAN-1:0] w_wr_sel;

   always_comb begin
      w_wr_sel = '0;
      for (int c = 0; c < NCHAN; c++) begin
         w_wr_sel[c] = w_wr_commit && w_is_ch && (w_ch_idx == 4'(c));
      end
   end

   // Per-channel configuration and period counters
   logic [2:0]       r_mode   [NCHAN];
   logic [CNT_W-1:0] r_period [NCHAN];
   logic [CNT_W-1:0] r_duty   [NCHAN];
   logic [CNT_W-1:0] r_cnt    [NCHAN];
   logic [NCHAN-1:0] r_run, r_lvl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NCHAN; c++) begin
            r_mode[c]   <= MODE_OFF;
            r_period[c] <= '0;
            r_duty[c]   <= '0;
            r_cnt[c]    <= '0;
         end
         r_run <= '0;
         r_lvl <= '0;
      end else begin
         for (int c = 0; c < NCHAN; c++) begin
            if (w_wr_sel[c] && (w_reg == REG_CTRL)) begin
               r_mode[c] <= data_in[2:0];
               r_run[c]  <= data_in[3];
               r_lvl[c]  <= data_in[4];
            end
            if (w_wr_sel[c] && (w_reg == REG_PERIOD)) r_period[c] <= data_in[CNT_W-1:0];
            if (w_wr_sel[c] && (w_reg == REG_DUTY)) r_duty[c] <= data_in[CNT_W-1:0];
            if (w_wr_sel[c] && ((w_reg == REG_CTRL) || (w_reg == REG_PERIOD))) r_cnt[c] <= '0;
            else if (!r_run[c] || (r_period[c] == '0)) r_cnt[c] <= '0;
            else if (r_cnt[c] >= (r_period[c] - CNT_W'(1))) r_cnt[c] <= '0;
            else r_cnt[c] <= r_cnt[c] + CNT_W'(1);
         end
      end
   end

   // Waveform generation; modes 5-7 fall through to off
   logic [NCHAN-1:0] w_wave, w_oe;

   always_comb begin
      w_wave = '0;
      w_oe   = '0;
      for (int c = 0; c < NCHAN; c++) begin
         case (r_mode[c])
            MODE_CONST: begin
               w_wave[c] = r_lvl[c];
               w_oe[c]   = 1'b1;
            end
            MODE_SQ: begin
               w_wave[c] = (r_period[c] != '0) && (r_cnt[c] < (r_period[c] >> 1));
               w_oe[c]   = 1'b1;
            end
            MODE_PWM: begin
               w_wave[c] = (r_period[c] != '0) && (r_cnt[c] < r_duty[c]);
               w_oe[c]   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   logic [NCHAN-1:0] r_pin_s1, r_pin_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pin_out  <= '0;
         pin_oe   <= '0;
         r_pin_s1 <= '0;
         r_pin_s2 <= '0;
      end else begin
         pin_out  <= w_wave;
         pin_oe   <= w_oe;
         r_pin_s1 <= pin_in;
         r_pin_s2 <= r_pin_s1;
      end
   end

`ifdef PIN_BANK_CAPTURE_EN
   localparam int unsigned FA_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] G_A = ADDR_W'(BASE + CH_WORDS);

   logic                  r_rd_q;
   logic [ADDR_W-1:0]     r_rd_addr;
   logic [NCHAN-1:0]      r_pin_q, r_pend, r_lvl_cap, r_mask;
   logic [10:0]           r_cap_ts [NCHAN];
   logic [10:0]           r_ts;
   logic [15:0]           r_fifo [FIFO_DEPTH];
   logic [FA_W-1:0]       r_wp, r_rp;
   logic [8:0]            r_count;
   logic                  r_ovf;

   logic                  w_rd_fall, w_is_g, w_have, w_full, w_push, w_pop;
   logic                  w_ovf_set, w_ovf_clr, w_ovf_nxt;
   logic [NCHAN-1:0]      w_edge, w_grant;
   logic [15:0]           w_entry;
   logic [8:0]            w_count_nxt;

   // Globals start on a 4-word boundary, so the low offset bits index them directly
   assign w_is_g    = w_in_win && !w_is_ch;
   assign w_rd_fall = r_rd_q & ~w_rd_s;
   assign w_have    = |r_pend;
   assign w_full    = (r_count == 9'(FIFO_DEPTH));
   assign w_push    = w_have && !w_full;
   assign w_pop     = w_rd_fall && (r_rd_addr == G_A) && (r_count != '0);
   assign w_ovf_clr = w_rd_fall && (r_rd_addr == (G_A + ADDR_W'(1)));

   // Lowest pending channel wins the single push slot
   always_comb begin
      w_edge  = '0;
      w_grant = '0;
      w_entry = '0;
      for (int c = 0; c < NCHAN; c++) begin
         w_edge[c] = (r_pin_s2[c] ^ r_pin_q[c]) && r_mask[c] && (r_mode[c] == MODE_IN);
      end
      for (int c = NCHAN - 1; c >= 0; c--) begin
         if (r_pend[c]) begin
            w_grant    = '0;
            w_grant[c] = 1'b1;
            w_entry    = {4'(c), r_lvl_cap[c], r_cap_ts[c]};
         end
      end
   end

   always_comb begin
      w_ovf_set   = (|(w_edge & r_pend & ~w_grant)) || (w_have && w_full);
      w_ovf_nxt   = w_ovf_set || (r_ovf && !w_ovf_clr);
      w_count_nxt = r_count;
      if (w_push && !w_pop) w_count_nxt = r_count + 9'd1;
      else if (!w_push && w_pop) w_count_nxt = r_count - 9'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_q    <= 1'b0;
         r_rd_addr <= '0;
         r_pin_q   <= '0;
         r_pend    <= '0;
         r_lvl_cap <= '0;
         r_mask    <= '0;
         r_ts      <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_count   <= '0;
         r_ovf     <= 1'b0;
         irq       <= 1'b0;
         for (int c = 0; c < NCHAN; c++) r_cap_ts[c] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      end else begin
         r_rd_q  <= w_rd_s;
         if (w_rd_s) r_rd_addr <= addr;
         r_pin_q <= r_pin_s2;
         r_ts    <= r_ts + 11'd1;
         r_pend  <= (r_pend & ~w_grant) | w_edge;
         for (int c = 0; c < NCHAN; c++) begin
            if (w_edge[c]) begin
               r_lvl_cap[c] <= r_pin_s2[c];
               r_cap_ts[c]  <= r_ts;
            end
         end
         if (w_wr_commit && w_is_g && (w_reg == 2'd2)) r_mask <= data_in[NCHAN-1:0];
         if (w_push) begin
            r_fifo[r_wp] <= w_entry;
            r_wp         <= r_wp + FA_W'(1);
         end
         if (w_pop) r_rp <= r_rp + FA_W'(1);
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_nxt;
         irq     <= (w_count_nxt != '0) || w_ovf_nxt;
      end
   end
`else
   assign irq = 1'b0;
`endif

   // Read mux: channel registers, then the global words when capture is built
   logic [15:0] w_rdata;

   always_comb begin
      w_rdata = '0;
      if (w_is_ch) begin
         for (int c = 0; c < NCHAN; c++) begin
            if (w_ch_idx == 4'(c)) begin
               case (w_reg)
                  REG_CTRL:   w_rdata = {11'd0, r_lvl[c], r_run[c], r_mode[c]};
                  REG_PERIOD: w_rdata = 16'(r_period[c]);
                  REG_DUTY:   w_rdata = 16'(r_duty[c]);
                  default:    w_rdata = {14'd0, pin_out[c], r_pin_s2[c]};
               endcase
            end
         end
      end
`ifdef PIN_BANK_CAPTURE_EN
      else if (w_is_g) begin
         case (w_reg)
            2'd0:    w_rdata = (r_count != '0) ? r_fifo[r_rp] : 16'd0;
            2'd1:    w_rdata = {r_ovf, 6'd0, r_count};
            2'd2:    w_rdata = 16'(r_mask);
            default: w_rdata = '0;
         endcase
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out <= '0;
      else data_out <= w_rd_s ? w_rdata : 16'd0;
   end

endmodule
